// File: rtl/control_fsm_pkg.sv
// ============================================================================
// control_fsm_pkg : state codes, opcode/ext fields, ALU and operand-B codes
//                   shared by the control FSM and the datapath.
// Revision        : 1.0
// ============================================================================
`default_nettype none

package control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_XOR = 5'b00010;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_CMP = 5'b00101;
    localparam logic [4:0] ALU_MOV = 5'b01000;

    localparam logic [1:0] BSRC_REG  = 2'd0;
    localparam logic [1:0] BSRC_SEXT = 2'd1;
    localparam logic [1:0] BSRC_ZEXT = 2'd2;
    localparam logic [1:0] BSRC_LUI  = 2'd3;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_ALU     = 2'd1,
        CLS_LOAD    = 2'd2,
        CLS_STOR    = 2'd3
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [4:0] alu;
        logic [1:0] bsrc;
        logic       sets_flags;
    } idec_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_write;
        logic       reg_write_src;
        logic       alu_A_src;
        logic       flag_en;
        logic [1:0] alu_B_src;
        logic [4:0] alu_cont;
    } ctrl_t;

    function automatic idec_t decode_inst(input logic [15:0] inst);
        idec_t d;
        d.cls        = CLS_ALU;
        d.alu        = ALU_ADD;
        d.bsrc       = BSRC_REG;
        d.sets_flags = 1'b0;
        case (inst[15:12])
            OP_RTYPE: begin
                case (inst[7:4])
                    EXT_AND: d.alu = ALU_AND;
                    EXT_OR:  d.alu = ALU_OR;
                    EXT_XOR: d.alu = ALU_XOR;
                    EXT_ADD: d.alu = ALU_ADD;
                    EXT_SUB: d.alu = ALU_SUB;
                    EXT_CMP: begin d.alu = ALU_CMP; d.sets_flags = 1'b1; end
                    EXT_MOV: d.alu = ALU_MOV;
                    default: d.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ANDI: begin d.alu = ALU_AND; d.bsrc = BSRC_ZEXT; end
            OP_ORI:  begin d.alu = ALU_OR;  d.bsrc = BSRC_ZEXT; end
            OP_XORI: begin d.alu = ALU_XOR; d.bsrc = BSRC_ZEXT; end
            OP_ADDI: begin d.alu = ALU_ADD; d.bsrc = BSRC_SEXT; end
            OP_SUBI: begin d.alu = ALU_SUB; d.bsrc = BSRC_SEXT; end
            OP_CMPI: begin d.alu = ALU_CMP; d.bsrc = BSRC_SEXT; d.sets_flags = 1'b1; end
            OP_MOVI: begin d.alu = ALU_MOV; d.bsrc = BSRC_SEXT; end
            // LUI passes the shifted immediate straight through the ALU
            OP_LUI:  begin d.alu = ALU_MOV; d.bsrc = BSRC_LUI; end
            OP_MEM: begin
                case (inst[7:4])
                    EXT_LOAD: d.cls = CLS_LOAD;
                    EXT_STOR: d.cls = CLS_STOR;
                    default:  d.cls = CLS_ILLEGAL;
                endcase
            end
            default: d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

    function automatic ctrl_t ctrl_for(input state_e st, input logic [15:0] inst);
        ctrl_t c;
        idec_t d;
        c = '0;
        d = decode_inst(inst);
        case (st)
            ST_FETCH: c.mem_req = 1'b1;
            ST_MEM: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = (d.cls == CLS_STOR);
            end
            ST_EXEC: begin
                c.alu_A_src = 1'b1;
                c.alu_B_src = d.bsrc;
                c.alu_cont  = d.alu;
                c.flag_en   = d.sets_flags;
                c.reg_write = ~d.sets_flags;
            end
            ST_WB: begin
                c.reg_write     = 1'b1;
                c.reg_write_src = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_fsm_if.sv
// ============================================================================
// control_fsm_if : memory handshake and datapath control bundle of control_fsm.
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface control_fsm_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic              iord;
    logic [DATA_W-1:0] ir;
    logic              pc_en;
    logic              reg_write;
    logic              reg_write_src;
    logic              alu_A_src;
    logic              flag_en;
    logic [1:0]        alu_B_src;
    logic [4:0]        alu_cont;
    logic              illegal;
    logic [3:0]        state;

    modport master (
        input  mem_rdata, mem_ack,
        output mem_req, mem_we, iord, ir, pc_en, reg_write, reg_write_src,
               alu_A_src, flag_en, alu_B_src, alu_cont, illegal, state
    );

    modport slave (
        output mem_rdata, mem_ack,
        input  mem_req, mem_we, iord, ir, pc_en, reg_write, reg_write_src,
               alu_A_src, flag_en, alu_B_src, alu_cont, illegal, state
    );
endinterface

`default_nettype wire

// File: rtl/control_fsm_step_sync.sv
// ============================================================================
// step_sync : two-flop synchronizer and falling-edge detector for the
//             active-low single-step button.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module step_sync (
    input  logic clk,
    input  logic reset,
    input  logic step_i,
    output logic pulse_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], step_i};
        end
    end

    assign pulse_o = sync_q[2] & ~sync_q[1];
endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// control_fsm : multicycle fetch/decode/execute controller with sticky
//               illegal flag; CONTROL_FSM_STEP_EN adds single-step gating.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
`ifdef CONTROL_FSM_STEP_EN
    ,
    input  logic          step
`endif
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       wait_q, wait_d;
    ctrl_t             ctrl_q;
    idec_t             w_dec;
    logic              w_timeout;
    logic              w_step_ok;
    logic              w_pc_en;

`ifdef CONTROL_FSM_STEP_EN
    logic w_step_pulse;
    logic armed_q;

    step_sync u_step_sync (
        .clk     (clk),
        .reset   (reset),
        .step_i  (step),
        .pulse_o (w_step_pulse)
    );

    // A press is remembered until the instruction it releases leaves FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q <= 1'b0;
        end else if (state_q == ST_FETCH && state_d == ST_DECODE) begin
            armed_q <= 1'b0;
        end else if (w_step_pulse) begin
            armed_q <= 1'b1;
        end
    end

    assign w_step_ok = armed_q | w_step_pulse;
`else
    assign w_step_ok = 1'b1;
`endif

    assign w_dec     = decode_inst(ir_q[15:0]);
    assign w_timeout = (MEM_TIMEOUT > 0) && (wait_q == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        wait_d    = '0;
        w_pc_en   = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ack && w_step_ok) begin
                    ir_d    = bus.mem_rdata;
                    w_pc_en = 1'b1;
                    state_d = ST_DECODE;
                end else if (!bus.mem_ack) begin
                    if (w_timeout) begin
                        illegal_d = 1'b1;
                    end else if (MEM_TIMEOUT > 0) begin
                        wait_d = wait_q + 32'd1;
                    end
                end
            end
            ST_DECODE: begin
                case (w_dec.cls)
                    CLS_ALU:             state_d = ST_EXEC;
                    CLS_LOAD, CLS_STOR:  state_d = ST_MEM;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_MEM: begin
                if (bus.mem_ack) begin
                    state_d = (w_dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end else if (MEM_TIMEOUT > 0) begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_RST;
        endcase
    end

    // Outputs are precomputed from the next state so they are registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RST;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            wait_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            wait_q    <= wait_d;
            ctrl_q    <= ctrl_for(state_d, ir_d[15:0]);
        end
    end

    assign bus.mem_req       = ctrl_q.mem_req;
    assign bus.mem_we        = ctrl_q.mem_we;
    assign bus.iord          = ctrl_q.iord;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.reg_write_src = ctrl_q.reg_write_src;
    assign bus.alu_A_src     = ctrl_q.alu_A_src;
    assign bus.flag_en       = ctrl_q.flag_en;
    assign bus.alu_B_src     = ctrl_q.alu_B_src;
    assign bus.alu_cont      = ctrl_q.alu_cont;
    assign bus.pc_en         = w_pc_en;
    assign bus.ir            = ir_q;
    assign bus.illegal       = illegal_q;
    assign bus.state         = state_q;
endmodule

`default_nettype wire
